mux_scan_sampler: RTL and testbench

MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

---
 rtl/mux_scan_pkg.sv | 27 ++
 rtl/mux_scan_next_chan.sv | 24 ++
 rtl/mux_scan_sampler.sv | 101 ++++++++++
 tb/tb_mux_scan_sampler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexed scan sampler.
// Holds the FSM state encoding, counter/channel sizing and a lowest-channel helper.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int CNT_W    = 4;
    localparam int NUM_CHAN = 4;
    localparam int SEL_W    = 2;

    // Lowest set bit of a mask; returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] first_chan(input logic [NUM_CHAN-1:0] mask);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_scan_next_chan.sv
// Combinational search for the next enabled channel strictly above the current one.
// found is low when no higher channel is enabled, which ends the scan.
module mux_scan_next_chan
    import mux_scan_pkg::*;
(
    input  logic [NUM_CHAN-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    next,
    output logic                found
);

    always_comb begin
        next  = '0;
        found = 1'b0;
        // Walk downwards so the lowest qualifying index is the one left behind.
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next  = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps an external 4:1 mux through the enabled channels, dwelling SETTLE_CYCLES per
// channel, and captures the mux output into a word handed off with valid/ready.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_CHAN-1:0] chan_mask,
    output logic [SEL_W-1:0]    sel,
    input  logic                mux_in,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_CHAN-1:0] out_data
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CHAN-1:0] mask_q, mask_d;
    logic [NUM_CHAN-1:0] shadow_q, shadow_d;

    logic [SEL_W-1:0]    next_sel;
    logic                next_found;
    logic                dwell_done;

    mux_scan_next_chan u_next_chan (
        .mask  (mask_q),
        .cur   (sel_q),
        .next  (next_sel),
        .found (next_found)
    );

    assign dwell_done = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;

        case (state_q)
            IDLE: begin
                if (start && (chan_mask != '0)) begin
                    mask_d   = chan_mask;
                    shadow_d = '0;
                    sel_d    = first_chan(chan_mask);
                    cnt_d    = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (dwell_done) begin
                    shadow_d[sel_q] = mux_in;
                    cnt_d           = '0;
                    if (next_found) begin
                        sel_d = next_sel;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = (state_q == SETTLE) || (state_q == DONE);
    assign out_valid = (state_q == DONE);
    assign out_data  = shadow_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench for mux_scan_sampler: directed vector table, corner-case sequences
// and randomized scans checked against a channel-list reference model.
module tb_mux_scan_sampler;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] chan_mask;
    logic [1:0] sel;
    logic       mux_in;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [3:0] mux_data;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] data;
        logic [3:0] exp_out;
        int         exp_lat;
    } vec_t;

    vec_t table_v[6];

    mux_scan_sampler #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chan_mask (chan_mask),
        .sel       (sel),
        .mux_in    (mux_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Behavioural downstream 4:1 mux.
    assign mux_in = mux_data[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one scan from the accepting edge up to the edge where out_valid rises.
    task automatic apply_stimulus(input logic [3:0] mask, input logic [3:0] data,
                                  input logic [3:0] exp_out, input int exp_lat,
                                  input bit rand_data, input bit change_mask);
        int         chans[$];
        int         ch;
        logic [3:0] model;
        model = '0;
        for (int i = 0; i < 4; i++) if (mask[i]) chans.push_back(i);
        start     = 1'b1;
        chan_mask = mask;
        mux_data  = data;
        step();
        start = 1'b0;
        if (change_mask) chan_mask = 4'b0001;
        for (int c = 1; c <= exp_lat; c++) begin
            if (rand_data) mux_data = 4'($urandom);
            ch = chans[(c - 1) / S];
            check_output("sel", 8'(sel), 8'(ch));
            check_output("busy", 8'(busy), 8'd1);
            check_output("valid_early", 8'(out_valid), 8'd0);
            if ((c % S) == 0) model[ch] = mux_data[ch];
            step();
        end
        check_output("valid_rise", 8'(out_valid), 8'd1);
        check_output("out_data", 8'(out_data), rand_data ? 8'(model) : 8'(exp_out));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output("valid_clear", 8'(out_valid), 8'd0);
        check_output("busy_idle", 8'(busy), 8'd0);
    endtask

    initial begin
        logic [3:0] held;
        logic [3:0] rmask;
        table_v[0] = '{4'b1111, 4'b1101, 4'b1101, 8};
        table_v[1] = '{4'b1010, 4'b1111, 4'b1010, 4};
        table_v[2] = '{4'b0001, 4'b1111, 4'b0001, 2};
        table_v[3] = '{4'b1000, 4'b0000, 4'b0000, 2};
        table_v[4] = '{4'b0110, 4'b1001, 4'b0000, 4};
        table_v[5] = '{4'b0101, 4'b0111, 4'b0101, 4};

        rst_n     = 1'b0;
        start     = 1'b0;
        chan_mask = '0;
        out_ready = 1'b0;
        mux_data  = '0;
        #3;
        check_output("rst_sel", 8'(sel), 8'd0);
        check_output("rst_busy", 8'(busy), 8'd0);
        check_output("rst_valid", 8'(out_valid), 8'd0);
        check_output("rst_data", 8'(out_data), 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] directed vector table");
        for (int v = 0; v < 6; v++) begin
            apply_stimulus(table_v[v].mask, table_v[v].data, table_v[v].exp_out,
                           table_v[v].exp_lat, 1'b0, 1'b0);
            handshake();
            check_output("idle_sel_hold", 8'(sel), 8'($clog2(int'(table_v[v].mask) + 1) - 1));
        end

        $display("[TB] backpressure");
        apply_stimulus(4'b1111, 4'b1101, 4'b1101, 8, 1'b0, 1'b0);
        mux_data = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            start     = c[0];
            chan_mask = 4'b0011;
            step();
            check_output("bp_valid", 8'(out_valid), 8'd1);
            check_output("bp_data", 8'(out_data), 8'h0d);
            check_output("bp_busy", 8'(busy), 8'd1);
        end
        start = 1'b1;
        handshake();
        step();
        start = 1'b0;
        check_output("post_hs_accept", 8'(busy), 8'd1);
        check_output("post_hs_sel", 8'(sel), 8'd0);
        for (int c = 0; c < 2 * S; c++) step();
        check_output("post_hs_done", 8'(out_valid), 8'd1);
        handshake();

        $display("[TB] zero mask");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output("ready_no_effect", 8'(busy), 8'd0);
        start     = 1'b1;
        chan_mask = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            step();
            check_output("zm_busy", 8'(busy), 8'd0);
            check_output("zm_valid", 8'(out_valid), 8'd0);
        end
        start = 1'b0;

        $display("[TB] mid-scan reset");
        start     = 1'b1;
        chan_mask = 4'b1111;
        mux_data  = 4'b1101;
        step();
        start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check_output("pre_rst_sel", 8'(sel), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mr_sel", 8'(sel), 8'd0);
        check_output("mr_busy", 8'(busy), 8'd0);
        check_output("mr_valid", 8'(out_valid), 8'd0);
        check_output("mr_data", 8'(out_data), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            check_output("mr_no_valid", 8'(out_valid), 8'd0);
        end
        apply_stimulus(4'b1111, 4'b0010, 4'b0010, 8, 1'b0, 1'b0);
        handshake();

        $display("[TB] mask change mid-scan");
        apply_stimulus(4'b1111, 4'b1011, 4'b1011, 8, 1'b0, 1'b1);
        handshake();

        $display("[TB] randomized scans");
        for (int r = 0; r < 20; r++) begin
            rmask = 4'($urandom_range(1, 15));
            held  = 4'($urandom);
            apply_stimulus(rmask, held, 4'b0000, $countones(rmask) * S, 1'b1, 1'b0);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                step();
                check_output("rnd_hold", 8'(out_valid), 8'd1);
            end
            handshake();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
